// File: rtl/p2s_cond.sv
// 4-lane parallel-to-serial transmitter: loads one word per lane and shifts all lanes
// out together, one bit per clock, with a frame marker on each word's first bit.
module p2s_cond #(
    parameter int         WIDTH   = 8,
    parameter logic [7:0] PATTERN = 8'hBC
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_ENB,
    input  logic [1:0]       IN_MODO,
    input  logic             IN_DIR,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] IN_LANE3,
    input  logic [WIDTH-1:0] IN_LANE2,
    input  logic [WIDTH-1:0] IN_LANE1,
    input  logic [WIDTH-1:0] IN_LANE0,
    output logic             OUT_READY,
    output logic [3:0]       OUT_LANE,
    output logic             OUT_FRAME,
    output logic             OUT_BUSY
);

    localparam int                CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]     LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH+7:0]  PAT_EXT = {{WIDTH{1'b0}}, PATTERN};
    localparam logic [WIDTH-1:0]  PAT_W   = PAT_EXT[WIDTH-1:0];

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic [WIDTH-1:0] sreg     [4];
    logic [WIDTH-1:0] lane_in  [4];
    logic [WIDTH-1:0] new_word [4];

    logic mode_data, mode_pat, at_last, boundary, take_data, load_pat, load;

    function automatic logic first_bit(input logic [WIDTH-1:0] w, input logic dir);
        return dir ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w, input logic dir);
        return dir ? (w >> 1) : (w << 1);
    endfunction

    assign mode_data = (IN_MODO == 2'b00) || (IN_MODO == 2'b10);
    assign mode_pat  = (IN_MODO == 2'b01);
    assign at_last   = (cnt == LAST);
    // A new word may start from IDLE or on the last bit of the current word.
    assign boundary  = (state == IDLE) || at_last;
    assign OUT_READY = IN_ENB && mode_data && boundary;
    assign take_data = OUT_READY && IN_VALID;
    assign load_pat  = IN_ENB && mode_pat && boundary;
    assign load      = take_data || load_pat;

    always_comb begin
        lane_in[0] = IN_LANE0;
        lane_in[1] = IN_LANE1;
        lane_in[2] = IN_LANE2;
        lane_in[3] = IN_LANE3;
        for (int i = 0; i < 4; i++) begin
            new_word[i] = lane_in[i];
            if (mode_pat)
                new_word[i] = PAT_W;
            else if (IN_MODO[1])
                new_word[i] = ~lane_in[i];
        end
    end

    // The first bit goes straight to the output on load; sreg keeps the remaining bits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_q     <= 1'b0;
            OUT_LANE  <= '0;
            OUT_FRAME <= 1'b0;
            OUT_BUSY  <= 1'b0;
            for (int i = 0; i < 4; i++) sreg[i] <= '0;
        end else if (IN_ENB) begin
            if (load) begin
                state     <= SHIFT;
                cnt       <= '0;
                dir_q     <= IN_DIR;
                OUT_FRAME <= 1'b1;
                OUT_BUSY  <= 1'b1;
                for (int i = 0; i < 4; i++) begin
                    OUT_LANE[i] <= first_bit(new_word[i], IN_DIR);
                    sreg[i]     <= advance(new_word[i], IN_DIR);
                end
            end else if (state == SHIFT) begin
                if (!at_last) begin
                    cnt       <= cnt + 1'b1;
                    OUT_FRAME <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        OUT_LANE[i] <= first_bit(sreg[i], dir_q);
                        sreg[i]     <= advance(sreg[i], dir_q);
                    end
                end else begin
                    state     <= IDLE;
                    OUT_LANE  <= '0;
                    OUT_FRAME <= 1'b0;
                    OUT_BUSY  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_p2s_cond.sv
// Directed bench for p2s_cond: per-cycle vector table plus hand-written corner sequences.
module tb_p2s_cond;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_ENB;
    logic [1:0] IN_MODO;
    logic       IN_DIR;
    logic       IN_VALID;
    logic [7:0] IN_LANE3, IN_LANE2, IN_LANE1, IN_LANE0;
    logic       OUT_READY;
    logic [3:0] OUT_LANE;
    logic       OUT_FRAME;
    logic       OUT_BUSY;

    int tests = 0;
    int fails = 0;

    p2s_cond #(.WIDTH(8), .PATTERN(8'hBC)) dut (
        .CLK(CLK), .RESET(RESET), .IN_ENB(IN_ENB), .IN_MODO(IN_MODO), .IN_DIR(IN_DIR),
        .IN_VALID(IN_VALID), .IN_LANE3(IN_LANE3), .IN_LANE2(IN_LANE2), .IN_LANE1(IN_LANE1),
        .IN_LANE0(IN_LANE0), .OUT_READY(OUT_READY), .OUT_LANE(OUT_LANE),
        .OUT_FRAME(OUT_FRAME), .OUT_BUSY(OUT_BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       enb;
        logic [1:0] modo;
        logic       dir;
        logic       valid;
        logic [7:0] l3, l2, l1, l0;
        logic       rdy;
        logic [3:0] lane;
        logic       frame;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic enb, input logic [1:0] modo, input logic dir,
                                input logic valid, input logic [7:0] l3, input logic [7:0] l2,
                                input logic [7:0] l1, input logic [7:0] l0, input logic rdy,
                                input logic [3:0] lane, input logic frame, input logic busy);
        vec_t v;
        v.enb = enb; v.modo = modo; v.dir = dir; v.valid = valid;
        v.l3 = l3; v.l2 = l2; v.l1 = l1; v.l0 = l0;
        v.rdy = rdy; v.lane = lane; v.frame = frame; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive on the falling edge, check READY before the rising edge, outputs just after it.
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge CLK);
        IN_ENB = v.enb; IN_MODO = v.modo; IN_DIR = v.dir; IN_VALID = v.valid;
        IN_LANE3 = v.l3; IN_LANE2 = v.l2; IN_LANE1 = v.l1; IN_LANE0 = v.l0;
        #1 chk({nm, "_rdy"}, 8'(OUT_READY), 8'(v.rdy));
        @(posedge CLK);
        #1;
        chk({nm, "_lane"},  8'(OUT_LANE),  8'(v.lane));
        chk({nm, "_frame"}, 8'(OUT_FRAME), 8'(v.frame));
        chk({nm, "_busy"},  8'(OUT_BUSY),  8'(v.busy));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] w;
        logic [3:0] seq2 [8];

        // Single word A5,3C,FF,00 MSB first: lane nibbles per bit position.
        seq2 = '{4'hA, 4'h2, 4'hE, 4'h6, 4'h6, 4'hE, 4'h2, 4'hA};
        tbl.push_back(mk(1, 2'b00, 0, 1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1, seq2[0], 1, 1));
        for (int j = 1; j < 8; j++)
            tbl.push_back(mk(1, 2'b00, 0, 0, 8'hA5, 8'h3C, 8'hFF, 8'h00, 0, seq2[j], 0, 1));
        tbl.push_back(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'h0, 0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'h0, 0, 0));
        // Back-to-back 01 then 80 on lane0, LSB first, VALID held.
        tbl.push_back(mk(1, 2'b00, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01, 1, 4'h1, 1, 1));
        for (int j = 1; j < 8; j++)
            tbl.push_back(mk(1, 2'b00, 1, 1, 8'h00, 8'h00, 8'h00, 8'h80, 0, 4'h0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 1, 1, 8'h00, 8'h00, 8'h00, 8'h80, 1, 4'h0, 1, 1));
        for (int j = 1; j < 7; j++)
            tbl.push_back(mk(1, 2'b00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'h0, 0, 1));
        tbl.push_back(mk(1, 2'b00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'h1, 0, 1));
        tbl.push_back(mk(1, 2'b00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'h0, 0, 0));

        RESET = 1'b1; IN_ENB = 1'b1; IN_MODO = 2'b00; IN_DIR = 1'b0; IN_VALID = 1'b0;
        IN_LANE3 = '0; IN_LANE2 = '0; IN_LANE1 = '0; IN_LANE0 = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("init_lane",  8'(OUT_LANE),  8'h00);
        chk("init_frame", 8'(OUT_FRAME), 8'h00);
        chk("init_busy",  8'(OUT_BUSY),  8'h00);
        @(negedge CLK);
        RESET = 1'b0;

        for (int k = 0; k < tbl.size(); k++)
            run_vec(tbl[k], $sformatf("vec%0d", k));

        // Pattern mode without handshake: BC LSB first on every lane.
        pat = 8'hBC;
        for (int j = 0; j < 16; j++)
            run_vec(mk(1, 2'b01, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,
                       {4{pat[j % 8]}}, (j % 8) == 0, 1), $sformatf("pat%0d", j));
        run_vec(mk(1, 2'b00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'h0, 0, 0), "pat_end");

        // Freeze for 3 cycles after bit 4 of 96 (MSB first).
        w = 8'h96;
        run_vec(mk(1, 2'b00, 0, 1, 8'h00, 8'h00, 8'h00, w, 1, {3'b000, w[7]}, 1, 1), "frz0");
        for (int j = 1; j < 5; j++)
            run_vec(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,
                       {3'b000, w[7-j]}, 0, 1), $sformatf("frz%0d", j));
        for (int j = 0; j < 3; j++)
            run_vec(mk(0, 2'b00, 0, 1, 8'h00, 8'h00, 8'h00, 8'h55, 0,
                       {3'b000, w[3]}, 0, 1), $sformatf("frz_hold%0d", j));
        for (int j = 5; j < 8; j++)
            run_vec(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0,
                       {3'b000, w[7-j]}, 0, 1), $sformatf("frz%0d", j));
        run_vec(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 4'h0, 0, 0), "frz_end");

        // Inverted data, then pause requested mid-word.
        w = 8'hF0;
        run_vec(mk(1, 2'b10, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 1, {3'b000, w[7]}, 1, 1), "inv0");
        for (int j = 1; j < 4; j++)
            run_vec(mk(1, 2'b10, 0, 0, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0,
                       {3'b000, w[7-j]}, 0, 1), $sformatf("inv%0d", j));
        for (int j = 4; j < 8; j++)
            run_vec(mk(1, 2'b11, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0,
                       {3'b000, w[7-j]}, 0, 1), $sformatf("inv%0d", j));
        run_vec(mk(1, 2'b11, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0, 4'h0, 0, 0), "inv_end");
        run_vec(mk(1, 2'b11, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0, 4'h0, 0, 0), "inv_idle");

        // Asynchronous reset mid-word, then a fresh frame.
        run_vec(mk(1, 2'b00, 0, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1, 4'hF, 1, 1), "rst0");
        run_vec(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'hF, 0, 1), "rst1");
        run_vec(mk(1, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 4'hF, 0, 1), "rst2");
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_async_lane",  8'(OUT_LANE),  8'h00);
        chk("rst_async_frame", 8'(OUT_FRAME), 8'h00);
        chk("rst_async_busy",  8'(OUT_BUSY),  8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        IN_ENB = 1'b1; IN_MODO = 2'b00; IN_VALID = 1'b0;
        #1 chk("rst_release_rdy", 8'(OUT_READY), 8'h01);
        run_vec(mk(1, 2'b00, 0, 1, 8'hA5, 8'h00, 8'h00, 8'h00, 1, 4'h8, 1, 1), "rst_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
